// File: rtl/sky130_fd_io__sio_bank_pkg.sv
// sky130_fd_io__sio_bank_pkg: sequencer state encoding, config field layout, reset values.
// Refgen write masking depends on SKY130_FD_IO_SIO_BANK_DFT_EN.
package sky130_fd_io__sio_bank_pkg;
  typedef enum logic [2:0] {
    OFF = 3'd0, SETTLE = 3'd1, REF_REL = 3'd2, PAD_REL = 3'd3,
    ACTIVE = 3'd4, UPD = 3'd5, DOWN = 3'd6
  } state_e;
  typedef struct packed {
    logic [2:0] dm;
    logic slow;
    logic vtrip_sel;
    logic inp_dis;
    logic vreg_en;
    logic ibuf_sel;
    logic hld_ovr;
    logic oe_n;
  } ch_cfg_t;
  typedef struct packed {
    logic [2:0] voh_sel;
    logic [1:0] vref_sel;
    logic vreg_en;
    logic ibuf_sel;
    logic vtrip_sel;
    logic dft;
  } ref_cfg_t;
  localparam int CNT_W = 10;
  localparam ch_cfg_t CH_CFG_RST = '{dm: 3'b001, inp_dis: 1'b1, oe_n: 1'b1, default: '0};
  function automatic ref_cfg_t ref_wr(input logic [8:0] d);
    ref_cfg_t r;
    r = ref_cfg_t'(d);
`ifndef SKY130_FD_IO_SIO_BANK_DFT_EN
    r.dft = 1'b0;
`endif
    return r;
  endfunction
endpackage

// File: rtl/sky130_fd_io__sio_bank_if.sv
// sky130_fd_io__sio_bank_if: config-write valid/ready channel.
interface sky130_fd_io__sio_bank_if #(parameter int NUM_CH = 2);
  logic CFG_VALID;
  logic CFG_READY;
  logic [$clog2(NUM_CH+1)-1:0] CFG_CH;
  logic [9:0] CFG_DATA;
  modport master (output CFG_VALID, CFG_CH, CFG_DATA, input CFG_READY);
  modport slave (input CFG_VALID, CFG_CH, CFG_DATA, output CFG_READY);
endinterface

// File: rtl/sky130_fd_io__sio_bank_settle_cnt.sv
// sky130_fd_io__sio_bank_settle_cnt: loadable down-counter that saturates at zero.
module sky130_fd_io__sio_bank_settle_cnt #(parameter int W = 10) (
  input  logic         CLK,
  input  logic         RESET_B,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge CLK)
    cnt_q <= !RESET_B ? '0 : load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign cnt_o = cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sky130_fd_io__sio_bank_seq.sv
// sky130_fd_io__sio_bank_seq: SIO bank power-up/hold-release sequencer with shadow config writes.
// Define SKY130_FD_IO_SIO_BANK_DFT_EN to expose REF_CFG[0] on DFT_REFGEN.
module sky130_fd_io__sio_bank_seq import sky130_fd_io__sio_bank_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int SETTLE_CYC = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_B,
  input  logic                   BANK_EN,
  input  logic                   VDDA_GOOD,
  sky130_fd_io__sio_bank_if.slave cfg,
  output logic                   ENABLE_H,
  output logic                   ENABLE_VDDA_H,
  output logic                   HLD_H_N_REFGEN,
  output logic [NUM_CH-1:0]      HLD_H_N,
  output logic [10*NUM_CH-1:0]   CH_CFG,
  output logic [8:0]             REF_CFG,
  output logic                   DFT_REFGEN,
  output logic                   BANK_READY,
  output logic [2:0]             STATE
);
  localparam int CW = $clog2(NUM_CH+1);
  localparam logic [CW-1:0] REF_ID = CW'(NUM_CH);
  state_e state_q;
  logic en_q, ref_hld_q;
  logic [NUM_CH-1:0] hld_q;
  ch_cfg_t [NUM_CH-1:0] ch_cfg_q;
  ref_cfg_t ref_cfg_q;
  logic [CW-1:0] upd_ch_q;
  logic [9:0] upd_data_q;
  logic up, load, dec, zero;
  logic [CNT_W-1:0] load_val, cnt;
  // One counter serves settle time, pad-release index and the two-cycle update window.
  always_comb begin
    up = BANK_EN && VDDA_GOOD;
    load = up && (state_q == OFF || state_q == REF_REL || (state_q == ACTIVE && cfg.CFG_VALID));
    load_val = state_q == OFF ? CNT_W'(SETTLE_CYC) : state_q == REF_REL ? CNT_W'(NUM_CH-1) : CNT_W'(1);
    dec = state_q == SETTLE || state_q == PAD_REL || state_q == UPD;
  end
  sky130_fd_io__sio_bank_settle_cnt #(.W(CNT_W)) u_cnt (
    .CLK(CLK), .RESET_B(RESET_B), .load_i(load), .dec_i(dec), .val_i(load_val),
    .cnt_o(cnt), .zero_o(zero)
  );
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q <= OFF;
      en_q <= 1'b0;
      ref_hld_q <= 1'b0;
      hld_q <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_cfg_q[i] <= CH_CFG_RST;
      ref_cfg_q <= '0;
      upd_ch_q <= '0;
      upd_data_q <= '0;
    end else if (state_q != OFF && state_q != DOWN && !up) begin
      state_q <= DOWN;
      hld_q <= '0;
      ref_hld_q <= 1'b0;
    end else begin
      case (state_q)
        OFF: if (up) begin
          state_q <= SETTLE;
          en_q <= 1'b1;
        end
        SETTLE: if (zero) begin
          state_q <= REF_REL;
          ref_hld_q <= 1'b1;
        end
        REF_REL: state_q <= PAD_REL;
        PAD_REL: begin
          for (int i = 0; i < NUM_CH; i++) if (cnt == CNT_W'(NUM_CH-1-i)) hld_q[i] <= 1'b1;
          if (zero) state_q <= ACTIVE;
        end
        ACTIVE: if (cfg.CFG_VALID && cfg.CFG_CH <= REF_ID) begin
          state_q <= UPD;
          upd_ch_q <= cfg.CFG_CH;
          upd_data_q <= cfg.CFG_DATA;
          for (int i = 0; i < NUM_CH; i++) if (cfg.CFG_CH == CW'(i)) hld_q[i] <= 1'b0;
          if (cfg.CFG_CH == REF_ID) ref_hld_q <= 1'b0;
        end
        UPD: if (!zero) begin
          for (int i = 0; i < NUM_CH; i++) if (upd_ch_q == CW'(i)) ch_cfg_q[i] <= ch_cfg_t'(upd_data_q);
          if (upd_ch_q == REF_ID) ref_cfg_q <= ref_wr(upd_data_q[8:0]);
        end else begin
          state_q <= ACTIVE;
          hld_q <= '1;
          ref_hld_q <= 1'b1;
        end
        DOWN: begin
          state_q <= OFF;
          en_q <= 1'b0;
        end
        default: state_q <= OFF;
      endcase
    end
  end
  assign cfg.CFG_READY = state_q == ACTIVE;
  assign BANK_READY = state_q == ACTIVE;
  assign STATE = state_q;
  assign ENABLE_H = en_q;
  assign ENABLE_VDDA_H = en_q;
  assign HLD_H_N_REFGEN = ref_hld_q;
  assign HLD_H_N = hld_q;
  assign CH_CFG = ch_cfg_q;
  assign REF_CFG = ref_cfg_q;
`ifdef SKY130_FD_IO_SIO_BANK_DFT_EN
  assign DFT_REFGEN = ref_cfg_q.dft;
`else
  assign DFT_REFGEN = 1'b0;
`endif
endmodule

// File: tb/tb_sky130_fd_io__sio_bank_seq.sv
// tb_sky130_fd_io__sio_bank_seq: timeline scoreboard for the SIO bank sequencer.
module tb_sky130_fd_io__sio_bank_seq;
  localparam int NUM_CH = 2;
  localparam int SETTLE_CYC = 16;
  localparam int CW = $clog2(NUM_CH+1);
  localparam int S_OFF = 0, S_SETTLE = 1, S_REF = 2, S_PAD = 3, S_ACTIVE = 4, S_UPD = 5, S_DOWN = 6;
  localparam logic [9:0] CH_RST = 10'h091;
  localparam int ALL = (1 << NUM_CH) - 1;
  typedef enum int {F_STATE, F_READY, F_BRDY, F_EN, F_ENV, F_HREF, F_HLD, F_CH0, F_CH1, F_REF, F_DFT} fld_e;
  typedef struct {int cyc; fld_e f; logic [31:0] v;} exp_t;
  logic CLK = 0, RESET_B = 0, BANK_EN = 0, VDDA_GOOD = 0;
  logic ENABLE_H, ENABLE_VDDA_H, HLD_H_N_REFGEN, DFT_REFGEN, BANK_READY;
  logic [NUM_CH-1:0] HLD_H_N;
  logic [10*NUM_CH-1:0] CH_CFG;
  logic [8:0] REF_CFG;
  logic [2:0] STATE;
  sky130_fd_io__sio_bank_if #(.NUM_CH(NUM_CH)) cfg ();
  sky130_fd_io__sio_bank_seq #(.NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE_CYC)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .BANK_EN(BANK_EN), .VDDA_GOOD(VDDA_GOOD), .cfg(cfg),
    .ENABLE_H(ENABLE_H), .ENABLE_VDDA_H(ENABLE_VDDA_H), .HLD_H_N_REFGEN(HLD_H_N_REFGEN),
    .HLD_H_N(HLD_H_N), .CH_CFG(CH_CFG), .REF_CFG(REF_CFG), .DFT_REFGEN(DFT_REFGEN),
    .BANK_READY(BANK_READY), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  exp_t sb[$];
  logic [9:0] m_ch[NUM_CH];
  logic [8:0] m_ref;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [31:0] act(fld_e f);
    case (f)
      F_STATE: return 32'(STATE);
      F_READY: return 32'(cfg.CFG_READY);
      F_BRDY:  return 32'(BANK_READY);
      F_EN:    return 32'(ENABLE_H);
      F_ENV:   return 32'(ENABLE_VDDA_H);
      F_HREF:  return 32'(HLD_H_N_REFGEN);
      F_HLD:   return 32'(HLD_H_N);
      F_CH0:   return 32'(CH_CFG[9:0]);
      F_CH1:   return 32'(CH_CFG[19:10]);
      F_REF:   return 32'(REF_CFG);
      default: return 32'(DFT_REFGEN);
    endcase
  endfunction
  // Monitor: every expectation due in this cycle is checked mid-cycle, then retired.
  always @(negedge CLK) begin
    logic [31:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        a = act(sb[i].f);
        n_cmp++;
        if (a !== sb[i].v) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %0h, want %0h", sb[i].f.name(), cyc, a, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end
  function automatic void push(int c, fld_e f, logic [31:0] v);
    sb.push_back('{c, f, v});
  endfunction
  function automatic logic [8:0] ref_exp(logic [9:0] d);
`ifdef SKY130_FD_IO_SIO_BANK_DFT_EN
    return d[8:0];
`else
    return {d[8:1], 1'b0};
`endif
  endfunction
  function automatic logic dft_exp();
`ifdef SKY130_FD_IO_SIO_BANK_DFT_EN
    return m_ref[0];
`else
    return 1'b0;
`endif
  endfunction
  function automatic void shadow(int c);
    push(c, F_CH0, 32'(m_ch[0]));
    push(c, F_CH1, 32'(m_ch[1]));
    push(c, F_REF, 32'(m_ref));
    push(c, F_DFT, 32'(dft_exp()));
  endfunction
  function automatic void expect_reset(int c);
    for (int k = 0; k < NUM_CH; k++) m_ch[k] = CH_RST;
    m_ref = '0;
    push(c, F_STATE, S_OFF); push(c, F_READY, 0); push(c, F_BRDY, 0);
    push(c, F_EN, 0); push(c, F_ENV, 0); push(c, F_HREF, 0); push(c, F_HLD, 0);
    shadow(c);
  endfunction
  task automatic step(int n);
    repeat (n) @(negedge CLK);
  endtask
  // Power-up timeline: SETTLE for SETTLE_CYC+1 cycles, one REF_REL cycle, channel k released k+1 cycles into PAD_REL.
  task automatic powerup(input bit abort, output int pad);
    int s, r;
    s = cyc + 1;
    r = s + SETTLE_CYC + 1;
    pad = r + 1;
    BANK_EN = 1; VDDA_GOOD = 1;
    for (int c = s; c < r; c++) push(c, F_STATE, S_SETTLE);
    push(s, F_EN, 1); push(s, F_ENV, 1); push(s, F_HLD, 0); push(s, F_HREF, 0); push(s, F_READY, 0);
    push(r - 1, F_HREF, 0); push(r, F_HREF, 1); push(r, F_STATE, S_REF);
    push(pad, F_STATE, S_PAD); push(pad, F_HLD, 0);
    if (!abort) begin
      for (int k = 0; k < NUM_CH; k++) push(pad + k + 1, F_HLD, (1 << (k + 1)) - 1);
      push(pad + NUM_CH - 1, F_BRDY, 0);
      push(pad + NUM_CH, F_BRDY, 1); push(pad + NUM_CH, F_READY, 1); push(pad + NUM_CH, F_STATE, S_ACTIVE);
      shadow(pad + NUM_CH);
    end
  endtask
  task automatic bring_up();
    int pad;
    powerup(0, pad);
    step(pad + NUM_CH - cyc);
  endtask
  task automatic wr(int ch, logic [9:0] d);
    int t;
    t = cyc;
    cfg.CFG_VALID = 1; cfg.CFG_CH = CW'(ch); cfg.CFG_DATA = d;
    shadow(t + 1);
    if (ch < NUM_CH) begin
      push(t + 1, F_STATE, S_UPD); push(t + 1, F_READY, 0);
      push(t + 1, F_HLD, ALL & ~(1 << ch)); push(t + 2, F_HLD, ALL & ~(1 << ch)); push(t + 1, F_HREF, 1);
      push(t + 3, F_HLD, ALL); push(t + 3, F_STATE, S_ACTIVE); push(t + 3, F_READY, 1);
      m_ch[ch] = d;
    end else if (ch == NUM_CH) begin
      push(t + 1, F_STATE, S_UPD); push(t + 1, F_HLD, ALL);
      push(t + 1, F_HREF, 0); push(t + 2, F_HREF, 0); push(t + 3, F_HREF, 1);
      push(t + 3, F_STATE, S_ACTIVE); push(t + 3, F_READY, 1);
      m_ref = ref_exp(d);
    end else begin
      push(t + 1, F_STATE, S_ACTIVE); push(t + 2, F_STATE, S_ACTIVE);
      push(t + 1, F_HLD, ALL); push(t + 2, F_HLD, ALL); push(t + 1, F_HREF, 1); push(t + 1, F_READY, 1);
    end
    shadow(t + 2);
    step(1);
    cfg.CFG_VALID = 0;
    step(2);
  endtask
  initial begin
    int t, pad;
    cfg.CFG_VALID = 0; cfg.CFG_CH = '0; cfg.CFG_DATA = '0;
    step(2);
    expect_reset(cyc + 1);
    step(2);
    RESET_B = 1;
    BANK_EN = 1;
    for (int c = 1; c <= 3; c++) push(cyc + c, F_STATE, S_OFF);
    step(4);
    bring_up();
    wr(1, 10'h2A5);
    wr(3, 10'h155);
    wr(2, 10'h1FF);
    wr(0, 10'h3C3);
    for (int n = 0; n < 40; n++) begin
      wr(int'($urandom_range(0, (1 << CW) - 1)), 10'($urandom));
      step(int'($urandom_range(0, 2)));
    end
    // Supply drop while an update is in flight: the target keeps its old value.
    t = cyc;
    cfg.CFG_VALID = 1; cfg.CFG_CH = CW'(1); cfg.CFG_DATA = 10'h0F0;
    push(t + 1, F_STATE, S_UPD); push(t + 1, F_HLD, ALL & ~2);
    step(1);
    cfg.CFG_VALID = 0; VDDA_GOOD = 0;
    push(t + 2, F_STATE, S_DOWN); push(t + 2, F_HLD, 0); push(t + 2, F_HREF, 0); push(t + 2, F_EN, 1);
    push(t + 3, F_STATE, S_OFF); push(t + 3, F_EN, 0); push(t + 3, F_ENV, 0); push(t + 3, F_HLD, 0);
    push(t + 5, F_HLD, 0); push(t + 5, F_HREF, 0);
    shadow(t + 2); shadow(t + 3);
    step(5);
    bring_up();
    // Shutdown and write request in the same cycle: shutdown wins.
    t = cyc;
    cfg.CFG_VALID = 1; cfg.CFG_CH = CW'(0); cfg.CFG_DATA = ~m_ch[0]; BANK_EN = 0;
    push(t + 1, F_STATE, S_DOWN); push(t + 1, F_HLD, 0); push(t + 1, F_HREF, 0); push(t + 1, F_READY, 0);
    push(t + 2, F_STATE, S_OFF); push(t + 2, F_EN, 0);
    shadow(t + 2); shadow(t + 4);
    step(1);
    cfg.CFG_VALID = 0;
    step(4);
    powerup(1, pad);
    step(pad - cyc);
    RESET_B = 0; BANK_EN = 0;
    expect_reset(cyc + 1);
    step(2);
    RESET_B = 1;
    step(2);
    bring_up();
    wr(2, 10'h1FF);
    wr(0, 10'h2A5);
    step(5);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
